// File: rtl/rvfi_commit_serializer.sv
// RVFI commit serializer: compacts the per-cycle multi-port commit bundle into a
// single in-order record stream over valid/ready, with drop accounting on overflow.
package rvfi_pkg;
    typedef struct packed {
        logic        valid;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [63:0] order;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } rvfi_instr_t;
endpackage

module rvfi_commit_serializer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter logic [7:0]  HART_ID         = 8'h00
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        clear_i,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output rvfi_pkg::rvfi_instr_t                       rvfi_o,
    output logic                                        valid_o,
    input  logic                                        ready_i,
    output logic [63:0]                                 seq_o,
    output logic [$clog2(DEPTH):0]                      level_o,
    output logic                                        overflow_o,
    output logic [31:0]                                 drop_cnt_o,
    output logic [7:0]                                  hart_id_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 2;

    rvfi_pkg::rvfi_instr_t r_mem [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [63:0]           r_seq;
    logic [31:0]           r_drop_cnt;
    logic                  r_overflow;

    logic [AW:0]           w_level;
    logic                  w_pop;
    logic [LW-1:0]         w_free;
    logic [LW-1:0]         w_rank;
    logic [LW-1:0]         w_push;
    logic [LW-1:0]         w_drop;
    logic [32:0]           w_drop_sum;
    logic                  w_we   [NR_COMMIT_PORTS];
    logic [AW-1:0]         w_widx [NR_COMMIT_PORTS];

    assign w_level = r_wptr - r_rptr;
    assign valid_o = (w_level != '0);
    assign w_pop   = valid_o && ready_i;
    assign w_free  = LW'(DEPTH) - LW'(w_level) + LW'(w_pop);

    // Rank each present record among this cycle's records; the first w_free ranks fit.
    always_comb begin
        w_rank = '0;
        w_push = '0;
        w_drop = '0;
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_we[i]   = 1'b0;
            w_widx[i] = '0;
            if (rvfi_i[i].valid || rvfi_i[i].trap) begin
                if (w_rank < w_free) begin
                    w_we[i]   = 1'b1;
                    w_widx[i] = r_wptr[AW-1:0] + w_rank[AW-1:0];
                    w_push    = w_push + LW'(1);
                end else begin
                    w_drop    = w_drop + LW'(1);
                end
                w_rank = w_rank + LW'(1);
            end
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + 33'(w_drop);

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (w_we[i] && !clear_i) begin
                r_mem[w_widx[i]] <= rvfi_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_seq      <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
                r_seq  <= r_seq + 64'd1;
            end
            // Flush overrides the pop's pointer move but the pop still consumes a sequence number.
            if (clear_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                r_wptr <= r_wptr + w_push[AW:0];
                if (w_drop != '0) begin
                    r_overflow <= 1'b1;
                    r_drop_cnt <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
                end
            end
        end
    end

    assign rvfi_o     = valid_o ? r_mem[r_rptr[AW-1:0]] : '0;
    assign seq_o      = r_seq;
    assign level_o    = w_level;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;
    assign hart_id_o  = HART_ID;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer: directed scenarios plus random traffic checked
// against a queue-based model of the record stream.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  HID   = 8'h5A;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic                 ready_i = 1'b0;
    rvfi_instr_t [NR-1:0] rvfi_in;
    rvfi_instr_t          rvfi_o;
    logic                 valid_o;
    logic [63:0]          seq_o;
    logic [3:0]           level_o;
    logic                 overflow_o;
    logic [31:0]          drop_cnt_o;
    logic [7:0]           hart_id_o;

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO contents as a queue, plus counters.
    rvfi_instr_t m_q[$];
    logic [63:0] m_seq;
    longint      m_drop;
    logic        m_ovf;

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS(NR),
        .DEPTH(DEPTH),
        .HART_ID(HID)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .clear_i(clear_i),
        .rvfi_i(rvfi_in),
        .rvfi_o(rvfi_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .seq_o(seq_o),
        .level_o(level_o),
        .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o),
        .hart_id_o(hart_id_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic rvfi_instr_t rand_rec(logic v, logic t, logic [31:0] pc);
        rvfi_instr_t r;
        r.valid     = v;
        r.trap      = t;
        r.halt      = 1'($urandom);
        r.intr      = 1'($urandom);
        r.mode      = 2'($urandom);
        r.order     = {$urandom, $urandom};
        r.insn      = $urandom;
        r.rd_addr   = 5'($urandom);
        r.rd_wdata  = $urandom;
        r.pc_rdata  = pc;
        r.pc_wdata  = pc + 32'd4;
        r.mem_addr  = $urandom;
        r.mem_wdata = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_seq  = '0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic idle_inputs();
        rvfi_in[0] = rand_rec(1'b0, 1'b0, $urandom);
        rvfi_in[1] = rand_rec(1'b0, 1'b0, $urandom);
        clear_i    = 1'b0;
    endtask

    // One clock: advance model with the current inputs, then settle 1 time unit past the edge.
    task automatic cycle();
        int  free, sz;
        bit  pop;
        sz   = m_q.size();
        pop  = (sz != 0) && ready_i;
        free = DEPTH - sz + (pop ? 1 : 0);
        @(posedge clk_i);
        if (pop) begin
            void'(m_q.pop_front());
            m_seq = m_seq + 64'd1;
        end
        if (clear_i) begin
            m_q.delete();
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (rvfi_in[p].valid || rvfi_in[p].trap) begin
                    if (free > 0) begin
                        m_q.push_back(rvfi_in[p]);
                        free--;
                    end else begin
                        m_drop++;
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        ready_i = 1'b0;
        rst_ni  = 1'b0;
        model_reset();
        #12;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
        total++; if (rvfi_o !== '0) begin bad++; $display("FAIL reset_rvfi: got %h exp 0", rvfi_o); end
        total++; if (seq_o !== 64'd0) begin bad++; $display("FAIL reset_seq: got %0d exp 0", seq_o); end
        total++; if (level_o !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d exp 0", level_o); end
        total++; if (overflow_o !== 1'b0 || drop_cnt_o !== 32'd0) begin
            bad++; $display("FAIL reset_drop: got ovf=%b cnt=%0d exp 0 0", overflow_o, drop_cnt_o);
        end
        total++; if (hart_id_o !== HID) begin bad++; $display("FAIL hart_id: got %h exp %h", hart_id_o, HID); end
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_single();
        ready_i    = 1'b1;
        rvfi_in[0] = rand_rec(1'b1, 1'b0, 32'h8000_0000);
        cycle();
        idle_inputs();
        total++; if (valid_o !== 1'b1 || rvfi_o.pc_rdata !== 32'h8000_0000) begin
            bad++; $display("FAIL single_out: got v=%b pc=%h exp 1 80000000", valid_o, rvfi_o.pc_rdata);
        end
        total++; if (seq_o !== 64'd0) begin bad++; $display("FAIL single_seq0: got %0d exp 0", seq_o); end
        total++; if (rvfi_o !== m_q[0]) begin bad++; $display("FAIL single_rec: got %h exp %h", rvfi_o, m_q[0]); end
        cycle();
        total++; if (seq_o !== 64'd1 || valid_o !== 1'b0) begin
            bad++; $display("FAIL single_pop: got seq=%0d v=%b exp 1 0", seq_o, valid_o);
        end
    endtask

    task automatic test_dual();
        ready_i    = 1'b1;
        rvfi_in[0] = rand_rec(1'b1, 1'b0, 32'h100);
        rvfi_in[1] = rand_rec(1'b1, 1'b0, 32'h104);
        cycle();
        idle_inputs();
        total++; if (level_o !== 4'd2 || rvfi_o.pc_rdata !== 32'h100) begin
            bad++; $display("FAIL dual_first: got lvl=%0d pc=%h exp 2 100", level_o, rvfi_o.pc_rdata);
        end
        cycle();
        total++; if (level_o !== 4'd1 || rvfi_o.pc_rdata !== 32'h104) begin
            bad++; $display("FAIL dual_second: got lvl=%0d pc=%h exp 1 104", level_o, rvfi_o.pc_rdata);
        end
        cycle();
        total++; if (level_o !== 4'd0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL dual_empty: got lvl=%0d v=%b exp 0 0", level_o, valid_o);
        end
    endtask

    task automatic test_trap();
        ready_i    = 1'b1;
        rvfi_in[1] = rand_rec(1'b0, 1'b1, 32'h200);
        cycle();
        idle_inputs();
        total++; if (level_o !== 4'd1 || valid_o !== 1'b1) begin
            bad++; $display("FAIL trap_level: got lvl=%0d v=%b exp 1 1", level_o, valid_o);
        end
        total++; if (rvfi_o.trap !== 1'b1 || rvfi_o.valid !== 1'b0 || rvfi_o.pc_rdata !== 32'h200) begin
            bad++; $display("FAIL trap_rec: got trap=%b valid=%b pc=%h exp 1 0 200",
                            rvfi_o.trap, rvfi_o.valid, rvfi_o.pc_rdata);
        end
        cycle();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL trap_drain: got v=%b exp 0", valid_o); end
    endtask

    task automatic test_overflow();
        rvfi_instr_t first;
        logic [31:0] exp_pc;
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rvfi_in[0] = rand_rec(1'b1, 1'b0, 32'h1000 + 32'(8 * k));
            rvfi_in[1] = rand_rec(1'b1, 1'b0, 32'h1004 + 32'(8 * k));
            if (k == 0) first = rvfi_in[0];
            cycle();
            total++; if (rvfi_o !== first) begin bad++; $display("FAIL hold_head: got %h exp %h", rvfi_o, first); end
        end
        total++; if (level_o !== 4'd8 || drop_cnt_o !== 32'd2 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf_state: got lvl=%0d cnt=%0d ovf=%b exp 8 2 1", level_o, drop_cnt_o, overflow_o);
        end
        total++; if (seq_o !== m_seq) begin bad++; $display("FAIL ovf_seq: got %0d exp %0d", seq_o, m_seq); end
        ready_i    = 1'b1;
        rvfi_in[0] = rand_rec(1'b1, 1'b0, 32'h2000);
        rvfi_in[1] = rand_rec(1'b1, 1'b0, 32'h2004);
        cycle();
        idle_inputs();
        total++; if (level_o !== 4'd8 || drop_cnt_o !== 32'd3 || rvfi_o.pc_rdata !== 32'h1004) begin
            bad++; $display("FAIL full_pop: got lvl=%0d cnt=%0d pc=%h exp 8 3 1004", level_o, drop_cnt_o, rvfi_o.pc_rdata);
        end
        for (int j = 0; j < 8; j++) begin
            exp_pc = (j < 7) ? 32'h1004 + 32'(4 * j) : 32'h2000;
            total++; if (rvfi_o.pc_rdata !== exp_pc || seq_o !== m_seq) begin
                bad++; $display("FAIL drain_%0d: got pc=%h seq=%0d exp %h %0d", j, rvfi_o.pc_rdata, seq_o, exp_pc, m_seq);
            end
            cycle();
        end
        total++; if (level_o !== 4'd0 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL drain_end: got lvl=%0d ovf=%b exp 0 1", level_o, overflow_o);
        end
    endtask

    task automatic test_clear_reset();
        logic [31:0] drop_before;
        logic [63:0] seq_before;
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvfi_in[0] = rand_rec(1'b1, 1'b0, 32'h3000 + 32'(8 * k));
            rvfi_in[1] = rand_rec(k < 2, 1'b0, 32'h3004 + 32'(8 * k));
            cycle();
        end
        total++; if (level_o !== 4'd5) begin bad++; $display("FAIL clr_pre_level: got %0d exp 5", level_o); end
        drop_before = drop_cnt_o;
        seq_before  = m_seq;
        clear_i     = 1'b1;
        ready_i     = 1'b1;
        rvfi_in[0]  = rand_rec(1'b1, 1'b0, 32'h4000);
        rvfi_in[1]  = rand_rec(1'b1, 1'b0, 32'h4004);
        cycle();
        idle_inputs();
        total++; if (level_o !== 4'd0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL clear_empty: got lvl=%0d v=%b exp 0 0", level_o, valid_o);
        end
        total++; if (drop_cnt_o !== drop_before || seq_o !== seq_before + 64'd1) begin
            bad++; $display("FAIL clear_counts: got cnt=%0d seq=%0d exp %0d %0d",
                            drop_cnt_o, seq_o, drop_before, seq_before + 64'd1);
        end
        ready_i    = 1'b0;
        rvfi_in[0] = rand_rec(1'b1, 1'b0, 32'h5000);
        rvfi_in[1] = rand_rec(1'b0, 1'b1, 32'h5004);
        cycle();
        cycle();
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        total++; if (valid_o !== 1'b0 || rvfi_o !== '0 || level_o !== 4'd0) begin
            bad++; $display("FAIL async_rst_fifo: got v=%b lvl=%0d rec=%h exp 0 0 0", valid_o, level_o, rvfi_o);
        end
        total++; if (seq_o !== 64'd0 || drop_cnt_o !== 32'd0 || overflow_o !== 1'b0) begin
            bad++; $display("FAIL async_rst_cnt: got seq=%0d cnt=%0d ovf=%b exp 0 0 0", seq_o, drop_cnt_o, overflow_o);
        end
        idle_inputs();
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        int unsigned sel;
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NR; p++) begin
                sel = $urandom_range(0, 5);
                rvfi_in[p] = rand_rec(sel inside {1, 2, 3, 5}, sel inside {4, 5}, $urandom);
            end
            ready_i = ($urandom_range(0, 9) < 4);
            clear_i = ($urandom_range(0, 63) == 0);
            cycle();
            total++; if (valid_o !== (m_q.size() != 0) || level_o !== 4'(m_q.size())) begin
                bad++; $display("FAIL rnd_level[%0d]: got v=%b lvl=%0d exp %b %0d", n, valid_o, level_o,
                                m_q.size() != 0, m_q.size());
            end
            total++; if (rvfi_o !== ((m_q.size() != 0) ? m_q[0] : '0)) begin
                bad++; $display("FAIL rnd_rec[%0d]: got %h", n, rvfi_o);
            end
            total++; if (seq_o !== m_seq || drop_cnt_o !== 32'(m_drop) || overflow_o !== m_ovf) begin
                bad++; $display("FAIL rnd_cnt[%0d]: got seq=%0d cnt=%0d ovf=%b exp %0d %0d %b", n,
                                seq_o, drop_cnt_o, overflow_o, m_seq, m_drop, m_ovf);
            end
        end
        idle_inputs();
        ready_i = 1'b1;
        for (int n = 0; n < 10; n++) cycle();
        total++; if (level_o !== 4'd0 || seq_o !== m_seq) begin
            bad++; $display("FAIL rnd_drain: got lvl=%0d seq=%0d exp 0 %0d", level_o, seq_o, m_seq);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_trap();
        test_overflow();
        test_clear_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
